timer_set_ctrl: RTL

Time-base and set-mode controller for the light timer. It keeps a 24-bit packed-BCD time value (HH:MM:SS), advances it once per second in run mode, and runs a button-driven set sequence that selects and increments each field. Its registered time output drives the display page selector, and its field-select and blink outputs drive the set-mode indication.

---
 rtl/timer_set_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/timer_set_ctrl.sv
// Light-timer time base: packed-BCD HH:MM:SS counter with one-second run mode
// and a button-driven set sequence (HH -> MM -> SS) with blinking field select.

// One BCD byte: computes the incremented value and flags the wrap point.
module timer_set_bcd_field #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  input  logic       inc,
  output logic [7:0] nxt,
  output logic       wrap
);
  logic [3:0] hi, lo;

  assign hi   = val[7:4];
  assign lo   = val[3:0];
  assign wrap = (val == MAX);

  always_comb begin
    nxt = val;
    if (inc) begin
      if (wrap)           nxt = 8'h00;
      else if (lo >= 4'd9) nxt = {hi + 4'd1, 4'd0};
      else                nxt = {hi, lo + 4'd1};
    end
  end
endmodule

module timer_set_ctrl #(
  parameter int TICK_DIV  = 50000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_btn_mode,
  input  logic        i_btn_inc,
  output logic [23:0] o_time,
  output logic [2:0]  o_field,
  output logic        o_blink,
  output logic        o_tick
);
  localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  // Field order follows o_time byte order: [2]=HH, [1]=MM, [0]=SS.
  localparam logic [2:0][7:0] FMAX = {8'h23, 8'h59, 8'h59};

  typedef enum logic [1:0] {RUN, SET_HH, SET_MM, SET_SS} state_e;

  state_e        state_q, state_d;
  logic [2:0]    field_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [BW-1:0] blink_cnt_q;
  logic          run_q, stay_run, tick_d, set_inc, state_chg;
  logic [2:0]    fld_inc, wrap;
  logic [23:0]   time_d;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= RUN;
    else       state_q <= state_d;
  end

  // Next-state logic: a mode pulse always advances, regardless of inc
  always_comb begin
    state_d = state_q;
    if (i_btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = SET_SS;
        SET_SS:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Output decode of the upcoming state, registered below as o_field
  always_comb begin
    field_d = 3'b000;
    case (state_d)
      SET_HH:  field_d = 3'b100;
      SET_MM:  field_d = 3'b010;
      SET_SS:  field_d = 3'b001;
      default: field_d = 3'b000;
    endcase
  end

  assign run_q     = (state_q == RUN);
  assign stay_run  = run_q && !i_btn_mode;
  assign state_chg = (state_d != state_q);
  assign tick_d    = stay_run && (presc_q == PRESC_LAST);
  assign set_inc   = !run_q && i_btn_inc && !i_btn_mode;
  assign presc_d   = (stay_run && !tick_d) ? presc_q + PW'(1) : '0;

  // o_field mirrors state_q, so it doubles as the set-mode field select.
  assign fld_inc[0] = tick_d                       | (set_inc & o_field[0]);
  assign fld_inc[1] = (tick_d & wrap[0])           | (set_inc & o_field[1]);
  assign fld_inc[2] = (tick_d & wrap[0] & wrap[1]) | (set_inc & o_field[2]);

  for (genvar g = 0; g < 3; g++) begin : g_fld
    timer_set_bcd_field #(.MAX(FMAX[g])) u_fld (
      .val  (o_time[g*8 +: 8]),
      .inc  (fld_inc[g]),
      .nxt  (time_d[g*8 +: 8]),
      .wrap (wrap[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      presc_q <= '0;
      o_time  <= '0;
      o_tick  <= 1'b0;
      o_field <= 3'b000;
    end else begin
      presc_q <= presc_d;
      o_time  <= time_d;
      o_tick  <= tick_d;
      o_field <= field_d;
    end
  end

  // Blink phase restarts from 0 on every mode change so each field starts visible-low
  always_ff @(posedge i_clk) begin
    if (i_rst || state_chg || run_q) begin
      blink_cnt_q <= '0;
      o_blink     <= 1'b0;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      o_blink     <= ~o_blink;
    end else begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
    end
  end
endmodule
